// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 16-bit pipelined core.
// Holds the PC, requests words from instruction memory and presents
// {instruction, pc_plus2, valid} to decode. A one-entry skid buffer catches
// a word that returns while decode is stalled, so no fetched word is lost.
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters for
// accepted words and miss cycles; without it the perf outputs are zero.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        valid,
    output logic        halted,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_miss_cycles
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_SKID = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_q, skid_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic        skid_halt_q, skid_halt_d;

    logic        slot_free;
    logic        rdata_is_hlt;
    logic [15:0] pc_inc;

    // Decode-side handshake and fetched-word decode used by the next-state logic
    assign slot_free    = !valid_q || !stall;
    assign rdata_is_hlt = (imem_rdata[15:12] == HLT_OPCODE);
    // PC arithmetic wraps naturally at 16 bits (16'hFFFE + 2 = 16'h0000)
    assign pc_inc       = pc_q + 16'd2;

    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign instruction = instr_q;
    assign pc_plus2    = pc2_q;
    assign valid       = valid_q;

    // Next-state and datapath: branch redirect overrides all normal operation
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc2_d       = pc2_q;
        valid_d     = valid_q;
        skid_d      = skid_q;
        skid_pc2_d  = skid_pc2_q;
        skid_halt_d = skid_halt_q;

        if (branch_taken) begin
            // Squash everything in flight, including a speculatively fetched HLT
            pc_d        = branch_target;
            valid_d     = 1'b0;
            skid_d      = 16'h0000;
            skid_pc2_d  = 16'h0000;
            skid_halt_d = 1'b0;
            state_d     = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (imem_ready) begin
                        if (!rdata_is_hlt) begin
                            pc_d = pc_inc;
                        end
                        if (slot_free) begin
                            instr_d = imem_rdata;
                            pc2_d   = pc_inc;
                            valid_d = 1'b1;
                            if (rdata_is_hlt) begin
                                state_d = S_HALT;
                            end
                        end else begin
                            // Decode is holding its word: park this one
                            skid_d      = imem_rdata;
                            skid_pc2_d  = pc_inc;
                            skid_halt_d = rdata_is_hlt;
                            state_d     = S_SKID;
                        end
                    end else if (slot_free) begin
                        valid_d = 1'b0;
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        instr_d     = skid_q;
                        pc2_d       = skid_pc2_q;
                        valid_d     = 1'b1;
                        skid_halt_d = 1'b0;
                        state_d     = skid_halt_q ? S_HALT : S_RUN;
                    end
                end
                S_HALT: begin
                    // Drop valid once decode has taken the HLT; keep the word itself
                    if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // Pipeline state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            pc2_q       <= 16'h0000;
            valid_q     <= 1'b0;
            skid_q      <= 16'h0000;
            skid_pc2_q  <= 16'h0000;
            skid_halt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc2_q       <= pc2_d;
            valid_q     <= valid_d;
            skid_q      <= skid_d;
            skid_pc2_q  <= skid_pc2_d;
            skid_halt_q <= skid_halt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_miss_q, perf_miss_d;

    // Saturating counters: accepted words and cycles spent waiting on memory
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_miss_d    = perf_miss_q;
        if (imem_req && imem_ready && !branch_taken && (perf_fetched_q != 16'hFFFF)) begin
            perf_fetched_d = perf_fetched_q + 16'd1;
        end
        if (imem_req && !imem_ready && (perf_miss_q != 16'hFFFF)) begin
            perf_miss_d = perf_miss_q + 16'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 16'h0000;
            perf_miss_q    <= 16'h0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_miss_q    <= perf_miss_d;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_miss_cycles = perf_miss_q;
`else
    assign perf_fetched     = 16'h0000;
    assign perf_miss_cycles = 16'h0000;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 16-bit pipelined processor; producer of the instruction word consumed by the decode stage.
- Holds the PC and requests words from the instruction memory/cache, which may stall on a miss.
- Presents {instruction, PC+2, valid} to decode.
- Handles the decode-stage stall, branch redirect and HLT detection using a one-entry skid buffer so that no fetched word is lost.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, opcode (bits 15-12) that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to the instruction memory.
- imem_addr  out  16  fetch address; always equals the current PC.
- imem_ready  in  1  imem_rdata is valid for imem_addr in this same cycle; 0 means cache miss/wait.
- imem_rdata  in  16  instruction word.
- stall  in  1  decode cannot accept this cycle; the output must hold.
- branch_taken  in  1  redirect/flush request.
- branch_target  in  16  new PC when branch_taken=1.
- instruction  out  16  registered instruction to decode.
- pc_plus2  out  16  registered PC+2 of that instruction.
- valid  out  1  instruction/pc_plus2 are meaningful.
- halted  out  1  fetch has stopped on HLT.
- perf_fetched  out  16  see Optional Feature.
- perf_miss_cycles  out  16  see Optional Feature.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=S_RUN, instruction=0, pc_plus2=0, valid=0.
  - Skid buffer empty, halted=0, perf counters=0.
- Priority: rst_n > branch_taken > normal operation.
- "Slot free" = !valid || !stall.
- PC arithmetic: 16-bit, wraps modulo 2^16 (16'hFFFE+2 = 16'h0000).

S_RUN:
- imem_req=1, imem_addr=pc.
- imem_ready=1 and slot free:
  - instruction<=imem_rdata, pc_plus2<=pc+2, valid<=1.
  - If opcode==HLT_OPCODE: pc holds and state<=S_HALT. Otherwise pc<=pc+2.
- imem_ready=1 and slot not free:
  - skid<=imem_rdata, skid_pc2<=pc+2, skid_halt<=(opcode==HLT_OPCODE).
  - pc<=pc+2 unless HLT.
  - state<=S_SKID.
- imem_ready=0 and slot free: valid<=0 (bubble).
- imem_ready=0 and slot not free: output holds.
- Latency: a word returned with ready at cycle N appears on instruction at N+1.
- Throughput: one instruction per cycle while ready=1 and stall=0.

S_SKID:
- imem_req=0.
- stall=1: output and skid hold.
- stall=0: instruction/pc_plus2<=skid contents, valid<=1; state<=skid_halt ? S_HALT : S_RUN.

S_HALT:
- imem_req=0, halted=1.
- stall=0: valid<=0 once the HLT has been accepted. Instruction keeps its last value.
- Remains in S_HALT until reset or branch_taken.

branch_taken=1 (any state):
- pc<=branch_target, valid<=0, skid emptied, skid_halt<=0, state<=S_RUN, halted<=0.
- Any imem_rdata in the same cycle is discarded.
- Effect: a speculatively fetched HLT is squashed.

Stall:
- stall with valid=0 has no effect (the slot is free).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on each word accepted from memory (imem_req && imem_ready && !branch_taken).
  - perf_miss_cycles increments on each cycle with imem_req && !imem_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: both outputs tied to 16'h0000 and no counter flops are instantiated.

Test Plan:
- Reset, ready=1 always, stall=0, words 0x1111, 0x2222 at 0x0000/0x0002 -> cycle 1: instruction=0x1111, pc_plus2=0x0002, valid=1; cycle 2: 0x2222, 0x0004.
- ready=0 for 3 cycles at pc=0x0010, then ready=1 with 0xA5A5 -> imem_addr stays 0x0010; valid=0 for 3 cycles; then instruction=0xA5A5, pc_plus2=0x0012; perf_miss_cycles=3 (with FETCH_PERF_CNT_EN).
- valid=1 with 0x1111, stall=1, ready returns 0x2222 -> S_SKID, imem_req=0, output holds 0x1111; stall=0 -> 0x2222/0x0004 next cycle, then fetch resumes at 0x0004; no word lost or duplicated.
- Fetch 0xF000 at 0x0020 -> instruction=0xF000, pc_plus2=0x0022, imem_req=0 thereafter, halted=1, imem_addr=0x0020.
- HLT fetched, then branch_taken=1 with target 0x0100 -> halted=0, valid=0, next fetch imem_addr=0x0100; simultaneous ready data is dropped.
- Branch to 0xFFFE, fetch 0x1234 -> pc_plus2=0x0000, next imem_addr=0x0000; rst_n asserted mid-stall in S_SKID -> all outputs clear immediately, imem_addr=RESET_PC.
